alu_shift_right_seq: RTL and testbench



---
 rtl/alu_shift_pkg.sv | 13 +
 rtl/alu_shift_right_stage.sv | 24 ++
 rtl/alu_shift_right_seq.sv | 113 +++++++++++
 tb/tb_alu_shift_right_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared types and default sizing for the RV32I ALU right-shift path.
package alu_shift_pkg;

    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_SHAMT_W = $clog2(DEFAULT_DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shift_state_e;

endpackage

// File: rtl/alu_shift_right_stage.sv
// One binary-weighted right-shift stage: shifts by 2^k with a fill bit,
// or passes the data through when the stage is not enabled.
module alu_shift_right_stage
    import alu_shift_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int K_W    = 3
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              fill,
    input  logic [K_W-1:0]    k,
    input  logic              en,
    output logic [DATA_W-1:0] data_out
);

    logic [2*DATA_W-1:0] ext;
    logic [DATA_W-1:0]   shifted;

    // Fill bits sit above the data so a plain logical shift pulls them in.
    assign ext      = {{DATA_W{fill}}, data_in};
    assign shifted  = DATA_W'(ext >> (DATA_W'(1) << k));
    assign data_out = en ? shifted : data_in;

endmodule

// File: rtl/alu_shift_right_seq.sv
// Multi-cycle SRL/SRA unit: one binary-weighted stage per clock, LSB of the
// shift amount first, with valid/ready handshakes on both sides.
// Optional build macro ALU_SHIFT_RIGHT_EARLY_EXIT_EN: leave SHIFT as soon as
// no higher shift-amount bits remain set.
module alu_shift_right_seq
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_arith,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_srl
);

    localparam int             K_W    = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_W - 1);

    shift_state_e        state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0]  shamt_q, shamt_d;
    logic                fill_q, fill_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [DATA_W-1:0]   stage_out;
    logic                last_stage;

    // Only the low shift-amount bits are meaningful; the rest are dropped.
    logic [DATA_W-SHAMT_W-1:0] unused_b_hi;
    assign unused_b_hi = i_b[DATA_W-1:SHAMT_W];

    alu_shift_right_stage #(
        .DATA_W (DATA_W),
        .K_W    (K_W)
    ) u_stage (
        .data_in  (data_q),
        .fill     (fill_q),
        .k        (k_q),
        .en       (shamt_q[k_q]),
        .data_out (stage_out)
    );

`ifdef ALU_SHIFT_RIGHT_EARLY_EXIT_EN
    // Finish once every shift-amount bit above the current stage is clear.
    assign last_stage = (k_q == K_LAST) || (((shamt_q >> k_q) >> 1) == '0);
`else
    assign last_stage = (k_q == K_LAST);
`endif

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        fill_d  = fill_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    data_d  = i_a;
                    shamt_d = i_b[SHAMT_W-1:0];
                    fill_d  = i_arith & i_a[DATA_W-1];
                    k_d     = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = stage_out;
                k_d    = k_q + K_W'(1);
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            fill_q  <= fill_d;
            k_q     <= k_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_srl   = data_q;

endmodule

// File: tb/tb_alu_shift_right_seq.sv
// Self-checking bench for alu_shift_right_seq: directed cases plus a
// randomized run against a behavioural shift model. Honours
// ALU_SHIFT_RIGHT_EARLY_EXIT_EN for the expected latency.
module tb_alu_shift_right_seq;

    localparam int LAT_LIMIT = 20;
    localparam int N_RANDOM  = 2000;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_arith;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_srl;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_shift_right_seq dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_arith (i_arith),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_srl   (o_srl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                              input logic arith);
        logic signed [31:0] sa;
        int                 sh;
        sh = int'(b % 32);
        sa = a;
        sa = sa >>> sh;
        return arith ? 32'(sa) : (a >> sh);
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
`ifdef ALU_SHIFT_RIGHT_EARLY_EXIT_EN
        int sh;
        int lat;
        sh  = int'(b % 32);
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            if (sh >= (1 << i)) lat = i + 1;
        end
        return lat;
`else
        return (b == 32'hFFFF_FFFF) ? 5 : 5;
`endif
    endfunction

    // One request through the whole handshake; stall = DONE cycles with
    // i_ready low, poke = hold a competing request during the stall.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic arith,
                          input int stall, input bit poke);
        logic [31:0] exp;
        int          lat;
        exp = ref_shift(a, b, arith);
        check("idle_ready", 32'(o_ready), 32'(1));
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_arith = arith;
        i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_arith = 1'($urandom);
        check("busy_ready", 32'(o_ready), 32'(0));
        lat = 0;
        while (!o_valid && lat < LAT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(ref_latency(b)));
        check("done_valid", 32'(o_valid), 32'(1));
        check("result", o_srl, exp);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                i_valid = 1'b1;
                i_a     = ~a;
                i_b     = b + 32'd1;
            end
            @(negedge clk);
            check("stall_valid", 32'(o_valid), 32'(1));
            check("stall_data", o_srl, exp);
            check("stall_ready", 32'(o_ready), 32'(0));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("post_valid", 32'(o_valid), 32'(0));
        check("post_ready", 32'(o_ready), 32'(1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'(1));
        check({tag, "_valid"}, 32'(o_valid), 32'(0));
        check({tag, "_data"}, o_srl, 32'h0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_arith = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        i_rst = 1'b0;

        // Directed cases.
        run_op(32'hF000_0000, 32'd4, 1'b0, 0, 1'b0);
        run_op(32'h8000_0000, 32'd31, 1'b1, 0, 1'b0);
        run_op(32'h8000_0000, 32'd31, 1'b0, 0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b1, 0, 1'b0);
        run_op(32'h8000_0001, 32'd16, 1'b1, 1, 1'b0);
        run_op(32'hFFFF_FFE0, 32'hFFFF_FFE2, 1'b1, 0, 1'b0);
        run_op(32'hDEAD_BEEF, 32'd1, 1'b1, 10, 1'b1);

        // Reset while the shifter is mid-operation (before stage 2).
        i_valid = 1'b1;
        i_a     = 32'hFFFF_FFFF;
        i_b     = 32'd31;
        i_arith = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_reset_state("rst_shift");
        run_op(32'h8765_4321, 32'd8, 1'b1, 0, 1'b0);

        // Reset while a result is waiting in DONE.
        i_valid = 1'b1;
        i_a     = 32'h7654_3210;
        i_b     = 32'd4;
        i_arith = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (LAT_LIMIT) @(negedge clk);
        check("pre_rst_valid", 32'(o_valid), 32'(1));
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_reset_state("rst_done");

        // Randomized regression with random back-pressure.
        for (int n = 0; n < N_RANDOM; n++) begin
            run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
